ifetch_unit: RTL

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: issues in-order memory reads from a fetch PC and
// buffers returned {instr, pc} pairs for decode, with redirect flush support.
//
// state | meaning
// FETCH | issuing requests, responses written into the instruction buffer
// FLUSH | waiting out responses to requests made before a redirect, data dropped
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        RedirectE,
  input  logic [31:0] RedirectPC,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemGnt,
  input  logic        IMemRValid,
  input  logic [31:0] IMemRData,
  output logic        InstrValidF,
  output logic [31:0] InstrF,
  output logic [31:0] PCPlus8
);

  localparam int PW = (BUF_DEPTH > 2) ? 2 : 1;

  typedef enum logic {FETCH = 1'b0, FLUSH = 1'b1} state_t;

  state_t        r_state;
  logic [31:0]   r_fpc;
  logic [2:0]    r_osd;
  logic [2:0]    r_drp;
  logic [2:0]    r_cnt;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [31:0]   r_buf_instr [BUF_DEPTH];
  logic [31:0]   r_buf_pc    [BUF_DEPTH];

  logic        w_hs;
  logic        w_push;
  logic        w_pop;
  logic [2:0]  w_inflight;
  logic [2:0]  w_drp_next;
  logic [31:0] w_resp_pc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign IMemAddr = r_fpc;
  assign IMemReq  = reset && (r_state == FETCH) && !RedirectE &&
                    ((r_osd + r_cnt) < 3'(BUF_DEPTH));
  assign w_hs     = IMemReq && IMemGnt;
  assign w_push   = (r_state == FETCH) && IMemRValid && (r_osd != 3'd0) && !RedirectE;
  assign w_pop    = (r_cnt != 3'd0) && !StallF && !RedirectE;

  // Requests since the last redirect are consecutive, so the oldest one in
  // flight sits osd words behind the fetch PC.
  assign w_resp_pc  = r_fpc - {27'b0, r_osd, 2'b00};

  // A response arriving with the redirect retires one of the requests in flight.
  assign w_inflight = r_osd + r_drp;
  assign w_drp_next = w_inflight - {2'b0, IMemRValid && (w_inflight != 3'd0)};

  assign InstrValidF = (r_cnt != 3'd0);
  assign InstrF      = InstrValidF ? r_buf_instr[r_rd_ptr] : '0;
  assign PCPlus8     = InstrValidF ? r_buf_pc[r_rd_ptr] + 32'd8 : '0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_instr[r_wr_ptr] <= IMemRData;
      r_buf_pc[r_wr_ptr]    <= w_resp_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= FETCH;
      r_fpc    <= RESET_PC;
      r_osd    <= '0;
      r_drp    <= '0;
      r_cnt    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (RedirectE) begin
      r_fpc    <= {RedirectPC[31:2], 2'b00};
      r_osd    <= '0;
      r_drp    <= w_drp_next;
      r_cnt    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_state  <= (w_drp_next != 3'd0) ? FLUSH : FETCH;
    end else begin
      if (w_hs) r_fpc <= r_fpc + 32'd4;
      r_osd <= r_osd + {2'b0, w_hs} - {2'b0, w_push};
      r_cnt <= r_cnt + {2'b0, w_push} - {2'b0, w_pop};
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if ((r_state == FLUSH) && IMemRValid) begin
        r_drp <= r_drp - 3'd1;
        if (r_drp == 3'd1) r_state <= FETCH;
      end
    end
  end

endmodule
